// File: rtl/tfhe_processor_slice.sv
// tfhe_processor_slice: one lane of the mini-TFHE processor.
// Encrypts two bytes under a fixed LWE secret (q=1024, p=256, delta=4),
// adds the ciphertexts homomorphically and decrypts the sum.
// Latency 3 cycles, one operation per cycle, no stalls.
// Optional build macro: TFHE_NOISE_EN adds 1-bit LFSR noise to each encryption.
module tfhe_processor_slice #(
  parameter logic [9:0]  SECRET_KEY = 10'd357,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] byte1,
  input  logic [9:0] public_key1,
  input  logic [7:0] byte2,
  input  logic [9:0] public_key2,
  output logic [7:0] res,
  output logic       out_valid
);

  localparam int DATA_W = 8;
  localparam int CT_W   = 10;
  localparam int STAGES = 3;

  // Ciphertexts are {a, b}; all arithmetic is mod 1024, i.e. the low 10 bits.
  logic [2*CT_W-1:0] ct1, ct2, ct_sum;
  logic [2*CT_W-1:0] ct1_d, ct2_d, ct_sum_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [STAGES-1:0] vld_q, vld_d;
  logic              e1, e2;

  // Product mod q: keep only the low 10 bits of the full product.
  function automatic logic [CT_W-1:0] mul_mod(input logic [CT_W-1:0] x,
                                              input logic [CT_W-1:0] y);
    logic [2*CT_W-1:0] prod;
    prod = x * y;
    return prod[CT_W-1:0];
  endfunction

  // LWE body: a*s + delta*m + e (mod q).
  function automatic logic [CT_W-1:0] enc_body(input logic [CT_W-1:0]   a,
                                               input logic [DATA_W-1:0] m,
                                               input logic              e);
    return mul_mod(a, SECRET_KEY) + {m, 2'b00} + {{(CT_W-1){1'b0}}, e};
  endfunction

  // Decode: phase = b - a*s (mod q); floor divide by delta drops the noise,
  // which is at most 2 and therefore always below delta.
  function automatic logic [DATA_W-1:0] dec_phase(input logic [2*CT_W-1:0] ct);
    logic [CT_W-1:0] phase;
    phase = ct[CT_W-1:0] - mul_mod(ct[2*CT_W-1:CT_W], SECRET_KEY);
    return phase[CT_W-1:2];
  endfunction

`ifdef TFHE_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Fibonacci LFSR (taps 16,14,13,11) steps once per accepted beat.
  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = in_valid ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign e1 = lfsr_q[0];
  assign e2 = lfsr_q[1];
`else
  assign e1 = 1'b0;
  assign e2 = 1'b0;
`endif

  // Datapath next state: encrypt, homomorphic add, decrypt.
  always_comb begin
    // stage 1: encrypt both operands
    ct1_d    = {public_key1, enc_body(public_key1, byte1, e1)};
    ct2_d    = {public_key2, enc_body(public_key2, byte2, e2)};
    // stage 2: component-wise ciphertext addition
    ct_sum_d = {ct1[2*CT_W-1:CT_W] + ct2[2*CT_W-1:CT_W],
                ct1[CT_W-1:0]      + ct2[CT_W-1:0]};
    // stage 3: decrypt the sum
    res_d    = dec_phase(ct_sum);
    vld_d    = {vld_q[STAGES-2:0], in_valid};
  end

  // Pipeline registers; data loads every cycle, valid follows in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ct1    <= '0;
      ct2    <= '0;
      ct_sum <= '0;
      res_q  <= '0;
      vld_q  <= '0;
    end else begin
      ct1    <= ct1_d;
      ct2    <= ct2_d;
      ct_sum <= ct_sum_d;
      res_q  <= res_d;
      vld_q  <= vld_d;
    end
  end

  assign res       = res_q;
  assign out_valid = vld_q[STAGES-1];

endmodule

// File: tb/tb_tfhe_processor_slice.sv
// Directed bench for tfhe_processor_slice with an expected-result queue.
module tb_tfhe_processor_slice;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] byte1, byte2;
  logic [9:0] public_key1, public_key2;
  logic [7:0] res;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] r;
    int         due;
  } exp_t;
  exp_t sb[$];

  tfhe_processor_slice dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .byte1(byte1), .public_key1(public_key1),
    .byte2(byte2), .public_key2(public_key2),
    .res(res), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] enc_b(input logic [9:0] pk, input logic [7:0] m);
    logic [19:0] p;
    p = pk * 20'd357;
    return p[9:0] + {m, 2'b00};
  endfunction

  // Advance one clock, then check the output against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("res", {24'b0, res}, {24'b0, sb[0].r});
      void'(sb.pop_front());
    end else begin
      chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b1, input logic [9:0] k1,
                       input logic [7:0] b2, input logic [9:0] k2);
    exp_t e;
    in_valid    = v;
    byte1       = b1;
    public_key1 = k1;
    byte2       = b2;
    public_key2 = k2;
    if (v && !rst) begin
      e.r   = b1 + b2;
      e.due = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic beat(input logic [7:0] b1, input logic [7:0] b2);
    drive(1'b1, b1, 10'($urandom_range(0, 1023)), b2, 10'($urandom_range(0, 1023)));
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 8'd0, 10'd0, 8'd0, 10'd0);
      tick();
    end
  endtask

  logic [7:0]  pa [6] = '{8'd5, 8'd10, 8'd50, 8'd16, 8'd64, 8'd37};
  logic [7:0]  pb [6] = '{8'd3, 8'd20, 8'd75, 8'd32, 8'd128, 8'd89};
  logic [7:0]  wa [4] = '{8'd255, 8'd200, 8'd255, 8'd111};
  logic [7:0]  wb [4] = '{8'd1, 8'd100, 8'd255, 8'd222};
  logic [7:0]  xb1, xb2;
  logic [9:0]  exp_b1, exp_b2;
  logic [19:0] probe;

  initial begin
    rst = 1'b1;
    drive(1'b1, 8'd9, 10'd3, 8'd9, 10'd4);
    tick();
    tick();
    chk("rst_res", {24'b0, res}, 32'd0);
    chk("rst_ct1", {12'b0, dut.ct1}, 32'd0);
    chk("rst_ct2", {12'b0, dut.ct2}, 32'd0);
    chk("rst_ct_sum", {12'b0, dut.ct_sum}, 32'd0);
    rst = 1'b0;
    idle(1);

    // zero operands
    beat(8'd0, 8'd0);
    idle(3);

    // back-to-back sums, then wrapping sums
    for (int i = 0; i < 6; i++) beat(pa[i], pb[i]);
    for (int i = 0; i < 4; i++) beat(wa[i], wb[i]);
    idle(4);

    // ciphertext probes: encryption body with public_key1=1
    drive(1'b1, 8'd5, 10'd1, 8'd7, 10'd2);
    tick();
    probe = dut.ct1;
    chk("ct1_a", {22'b0, probe[19:10]}, 32'd1);
`ifdef TFHE_NOISE_EN
    chk("ct1_b_noisy", {31'b0, (probe[9:0] == 10'd377) || (probe[9:0] == 10'd378)}, 32'd1);
`else
    chk("ct1_b", {22'b0, probe[9:0]}, 32'd377);
`endif
    idle(3);

    // homomorphic add with masks wrapping mod 1024
    for (int i = 0; i < 3; i++) begin
      xb1 = 8'($urandom_range(0, 255));
      xb2 = 8'($urandom_range(0, 255));
      exp_b1 = enc_b(10'd1000, xb1);
      exp_b2 = enc_b(10'd100, xb2);
      drive(1'b1, xb1, 10'd1000, xb2, 10'd100);
      tick();
`ifndef TFHE_NOISE_EN
      chk("ct2_b", {22'b0, dut.ct2[9:0]}, {22'b0, exp_b2});
`endif
      drive(1'b0, 8'd0, 10'd0, 8'd0, 10'd0);
      tick();
      probe = dut.ct_sum;
      chk("ct_sum_a", {22'b0, probe[19:10]}, 32'd76);
`ifndef TFHE_NOISE_EN
      chk("ct_sum_b", {22'b0, probe[9:0]}, {22'b0, 10'(exp_b1 + exp_b2)});
`endif
      idle(2);
    end

    // reset with two operations in flight; in_valid during reset ignored
    beat(8'd12, 8'd34);
    beat(8'd56, 8'd78);
    rst = 1'b1;
    sb.delete();
    drive(1'b1, 8'd1, 10'd1, 8'd1, 10'd1);
    tick();
    chk("midrst_res", {24'b0, res}, 32'd0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    idle(5);

    // recovery after reset
    beat(8'd100, 8'd27);
    idle(4);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
